urv_dm_arbiter: RTL and testbench

Data-memory port arbiter placed between the uRV execute stage and the single data-memory bus. It shares the bus between the CPU (single-cycle load/store pulses from the execute stage) and a debug master (level req/ack handshake). It latches requests, sequences one memory transaction at a time with variable memory latency, and stalls the CPU pipeline while a CPU access is pending or in flight.

---
 rtl/urv_dm_arbiter_pkg.sv | 23 ++
 rtl/urv_dm_req_latch.sv | 29 ++
 rtl/urv_dm_arbiter.sv | 130 +++++++++++++
 tb/tb_urv_dm_arbiter.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/urv_dm_arbiter_pkg.sv
// Shared definitions for the uRV data-memory arbiter: state encodings,
// requester IDs and the captured-request record.
package urv_dm_arbiter_pkg;

  typedef enum logic [1:0] {
    URV_DMA_IDLE = 2'd0,
    URV_DMA_CPU  = 2'd1,
    URV_DMA_DBG  = 2'd2
  } dma_state_t;

  typedef enum logic {
    URV_DMA_REQ_CPU = 1'b0,
    URV_DMA_REQ_DBG = 1'b1
  } dma_requester_t;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  sel;
    logic        we;
  } dma_req_t;

endpackage

// File: rtl/urv_dm_req_latch.sv
// Single-entry request holding register with a valid flag; a clear and a
// load in the same cycle leave the new request captured.
module urv_dm_req_latch
  import urv_dm_arbiter_pkg::*;
(
  input  logic     clk_i,
  input  logic     rst_i,
  input  logic     load,
  input  logic     clear,
  input  dma_req_t d,
  output dma_req_t q,
  output logic     valid
);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      q     <= '0;
      valid <= 1'b0;
    end else begin
      if (clear)
        valid <= 1'b0;
      if (load) begin
        q     <= d;
        valid <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/urv_dm_arbiter.sv
// Shares the single data-memory bus between CPU load/store pulses and a
// debug req/ack master, one transaction at a time.
module urv_dm_arbiter
  import urv_dm_arbiter_pkg::*;
#(
  parameter int g_starve_limit = 4
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [31:0] cpu_addr_i,
  input  logic [31:0] cpu_data_i,
  input  logic [3:0]  cpu_sel_i,
  input  logic        cpu_load_i,
  input  logic        cpu_store_i,
  output logic        cpu_stall_req_o,
  output logic        cpu_load_done_o,
  output logic [31:0] cpu_data_o,
  input  logic [31:0] dbg_addr_i,
  input  logic [31:0] dbg_data_i,
  input  logic [3:0]  dbg_sel_i,
  input  logic        dbg_we_i,
  input  logic        dbg_req_i,
  output logic        dbg_ack_o,
  output logic [31:0] dbg_data_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_data_o,
  output logic [3:0]  mem_sel_o,
  output logic        mem_we_o,
  output logic        mem_req_o,
  input  logic        mem_ack_i,
  input  logic [31:0] mem_data_i
);

  localparam logic [3:0] STARVE_LIMIT = 4'(g_starve_limit);

  dma_state_t     state, state_next;
  dma_requester_t grant_src;
  dma_req_t       pulse_req, pend_req, cpu_req, dbg_req, grant_req;
  logic           pend_valid, pend_load, pend_clear;
  logic           cpu_pulse, cpu_cand, dbg_cand, arb_point;
  logic           grant_cpu, grant_dbg;
  logic [3:0]     starve_cnt;

  urv_dm_req_latch u_cpu_pending (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .load  (pend_load),
    .clear (pend_clear),
    .d     (pulse_req),
    .q     (pend_req),
    .valid (pend_valid)
  );

  // A debug request that is completing now, or whose ack is still visible,
  // is stale and must not be granted a second time.
  always_comb begin
    cpu_pulse  = (cpu_load_i | cpu_store_i) & ~pend_valid;
    pulse_req  = '{addr: cpu_addr_i, data: cpu_data_i, sel: cpu_sel_i, we: cpu_store_i};
    dbg_req    = '{addr: dbg_addr_i, data: dbg_data_i, sel: dbg_sel_i, we: dbg_we_i};
    cpu_req    = pend_valid ? pend_req : pulse_req;
    arb_point  = (state == URV_DMA_IDLE) | mem_ack_i;
    cpu_cand   = pend_valid | cpu_pulse;
    dbg_cand   = dbg_req_i & ~((state == URV_DMA_DBG) & mem_ack_i) & ~dbg_ack_o;
    grant_cpu  = arb_point & cpu_cand & ~(dbg_cand & (starve_cnt == STARVE_LIMIT));
    grant_dbg  = arb_point & dbg_cand & ~grant_cpu;
    grant_src  = grant_dbg ? URV_DMA_REQ_DBG : URV_DMA_REQ_CPU;
    grant_req  = (grant_src == URV_DMA_REQ_DBG) ? dbg_req : cpu_req;
    pend_load  = cpu_pulse & ~grant_cpu;
    pend_clear = pend_valid & grant_cpu;

    state_next = state;
    if (grant_cpu)
      state_next = URV_DMA_CPU;
    else if (grant_dbg)
      state_next = URV_DMA_DBG;
    else if (arb_point)
      state_next = URV_DMA_IDLE;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)
      state <= URV_DMA_IDLE;
    else
      state <= state_next;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cpu_load_done_o <= 1'b0;
      cpu_data_o      <= '0;
      dbg_ack_o       <= 1'b0;
      dbg_data_o      <= '0;
      mem_addr_o      <= '0;
      mem_data_o      <= '0;
      mem_sel_o       <= '0;
      mem_we_o        <= 1'b0;
    end else begin
      cpu_load_done_o <= (state == URV_DMA_CPU) & mem_ack_i & ~mem_we_o;
      dbg_ack_o       <= (state == URV_DMA_DBG) & mem_ack_i;
      if ((state == URV_DMA_CPU) && mem_ack_i && !mem_we_o)
        cpu_data_o <= mem_data_i;
      if ((state == URV_DMA_DBG) && mem_ack_i)
        dbg_data_o <= mem_data_i;
      if (grant_cpu || grant_dbg) begin
        mem_addr_o <= grant_req.addr;
        mem_data_o <= grant_req.data;
        mem_sel_o  <= grant_req.sel;
        mem_we_o   <= grant_req.we;
      end
    end
  end

  // Counts CPU wins that left debug waiting; saturates at the limit.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)
      starve_cnt <= '0;
    else if (!dbg_req_i || grant_dbg)
      starve_cnt <= '0;
    else if (grant_cpu && starve_cnt != STARVE_LIMIT)
      starve_cnt <= starve_cnt + 4'd1;
  end

  assign mem_req_o       = (state != URV_DMA_IDLE);
  assign cpu_stall_req_o = pend_valid | (state == URV_DMA_CPU);

  cpu_pulse_while_pending: assert property (
    @(posedge clk_i) disable iff (rst_i) !(pend_valid && (cpu_load_i || cpu_store_i))
  );

endmodule

// File: tb/tb_urv_dm_arbiter.sv
// Directed self-checking bench for urv_dm_arbiter, built with a starve
// limit of 2 so the forced debug win is reachable in a short sequence.
module tb_urv_dm_arbiter;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic [31:0] cpu_addr_i, cpu_data_i, dbg_addr_i, dbg_data_i, mem_data_i;
  logic [3:0]  cpu_sel_i, dbg_sel_i;
  logic        cpu_load_i, cpu_store_i, dbg_we_i, dbg_req_i, mem_ack_i;
  logic        cpu_stall_req_o, cpu_load_done_o, dbg_ack_o, mem_we_o, mem_req_o;
  logic [31:0] cpu_data_o, dbg_data_o, mem_addr_o, mem_data_o;
  logic [3:0]  mem_sel_o;

  int tests_run = 0;
  int tests_failed = 0;
  int stall_cycles;

  urv_dm_arbiter #(.g_starve_limit(2)) dut (
    .clk_i           (clk_i),
    .rst_i           (rst_i),
    .cpu_addr_i      (cpu_addr_i),
    .cpu_data_i      (cpu_data_i),
    .cpu_sel_i       (cpu_sel_i),
    .cpu_load_i      (cpu_load_i),
    .cpu_store_i     (cpu_store_i),
    .cpu_stall_req_o (cpu_stall_req_o),
    .cpu_load_done_o (cpu_load_done_o),
    .cpu_data_o      (cpu_data_o),
    .dbg_addr_i      (dbg_addr_i),
    .dbg_data_i      (dbg_data_i),
    .dbg_sel_i       (dbg_sel_i),
    .dbg_we_i        (dbg_we_i),
    .dbg_req_i       (dbg_req_i),
    .dbg_ack_o       (dbg_ack_o),
    .dbg_data_o      (dbg_data_o),
    .mem_addr_o      (mem_addr_o),
    .mem_data_o      (mem_data_o),
    .mem_sel_o       (mem_sel_o),
    .mem_we_o        (mem_we_o),
    .mem_req_o       (mem_req_o),
    .mem_ack_i       (mem_ack_i),
    .mem_data_i      (mem_data_i)
  );

  always #5 clk_i = ~clk_i;

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic check_output(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, actual, expected);
    end
  endtask

  initial begin
    rst_i = 1'b1;
    cpu_addr_i = '0; cpu_data_i = '0; cpu_sel_i = '0; cpu_load_i = 1'b0; cpu_store_i = 1'b0;
    dbg_addr_i = '0; dbg_data_i = '0; dbg_sel_i = '0; dbg_we_i = 1'b0; dbg_req_i = 1'b0;
    mem_ack_i = 1'b0; mem_data_i = '0;
    #2;
    check_output("rst_mem_req", 32'(mem_req_o), 32'd0);
    check_output("rst_stall", 32'(cpu_stall_req_o), 32'd0);
    check_output("rst_done", 32'(cpu_load_done_o), 32'd0);
    check_output("rst_dbg_ack", 32'(dbg_ack_o), 32'd0);
    check_output("rst_mem_addr", mem_addr_o, 32'd0);
    check_output("rst_cpu_data", cpu_data_o, 32'd0);
    check_output("rst_dbg_data", dbg_data_o, 32'd0);
    tick(); tick();
    rst_i = 1'b0;
    tick();

    // CPU load with three-cycle memory latency
    cpu_load_i = 1'b1; cpu_addr_i = 32'h100; cpu_sel_i = 4'hF;
    tick();
    cpu_load_i = 1'b0;
    check_output("a_mem_req", 32'(mem_req_o), 32'd1);
    check_output("a_mem_addr", mem_addr_o, 32'h100);
    check_output("a_mem_we", 32'(mem_we_o), 32'd0);
    stall_cycles = 0;
    for (int i = 0; i < 3; i++) begin
      if (cpu_stall_req_o) stall_cycles++;
      check_output("a_no_early_done", 32'(cpu_load_done_o), 32'd0);
      if (i == 2) begin mem_ack_i = 1'b1; mem_data_i = 32'hDEADBEEF; end
      tick();
      mem_ack_i = 1'b0;
    end
    check_output("a_stall_cycles", 32'(stall_cycles), 32'd3);
    check_output("a_done", 32'(cpu_load_done_o), 32'd1);
    check_output("a_cpu_data", cpu_data_o, 32'hDEADBEEF);
    check_output("a_stall_off", 32'(cpu_stall_req_o), 32'd0);
    check_output("a_mem_idle", 32'(mem_req_o), 32'd0);
    tick();
    check_output("a_done_pulse", 32'(cpu_load_done_o), 32'd0);
    check_output("a_data_hold", cpu_data_o, 32'hDEADBEEF);

    // Debug write while idle
    dbg_req_i = 1'b1; dbg_we_i = 1'b1; dbg_addr_i = 32'h200; dbg_data_i = 32'h55; dbg_sel_i = 4'hF;
    tick();
    check_output("b_mem_req", 32'(mem_req_o), 32'd1);
    check_output("b_mem_we", 32'(mem_we_o), 32'd1);
    check_output("b_mem_addr", mem_addr_o, 32'h200);
    check_output("b_mem_data", mem_data_o, 32'h55);
    check_output("b_no_stall", 32'(cpu_stall_req_o), 32'd0);
    mem_ack_i = 1'b1; mem_data_i = 32'h1234;
    tick();
    mem_ack_i = 1'b0;
    check_output("b_dbg_ack", 32'(dbg_ack_o), 32'd1);
    check_output("b_dbg_data", dbg_data_o, 32'h1234);
    check_output("b_mem_idle", 32'(mem_req_o), 32'd0);
    tick();
    dbg_req_i = 1'b0;
    check_output("b_ack_pulse", 32'(dbg_ack_o), 32'd0);
    check_output("b_no_regrant", 32'(mem_req_o), 32'd0);
    check_output("b_no_stall2", 32'(cpu_stall_req_o), 32'd0);

    // CPU store arriving during a debug read
    dbg_req_i = 1'b1; dbg_we_i = 1'b0; dbg_addr_i = 32'h300;
    tick();
    cpu_store_i = 1'b1; cpu_addr_i = 32'h400; cpu_data_i = 32'hCAFEF00D; cpu_sel_i = 4'b0011;
    tick();
    cpu_store_i = 1'b0;
    check_output("c_stall", 32'(cpu_stall_req_o), 32'd1);
    check_output("c_dbg_addr", mem_addr_o, 32'h300);
    mem_ack_i = 1'b1; mem_data_i = 32'hAAAA5555;
    tick();
    mem_ack_i = 1'b0;
    check_output("c_dbg_ack", 32'(dbg_ack_o), 32'd1);
    check_output("c_dbg_data", dbg_data_o, 32'hAAAA5555);
    check_output("c_mem_req", 32'(mem_req_o), 32'd1);
    check_output("c_st_addr", mem_addr_o, 32'h400);
    check_output("c_st_we", 32'(mem_we_o), 32'd1);
    check_output("c_st_sel", 32'(mem_sel_o), 32'h3);
    check_output("c_st_data", mem_data_o, 32'hCAFEF00D);
    check_output("c_stall2", 32'(cpu_stall_req_o), 32'd1);
    dbg_req_i = 1'b0; mem_ack_i = 1'b1;
    tick();
    mem_ack_i = 1'b0;
    check_output("c_no_done", 32'(cpu_load_done_o), 32'd0);
    check_output("c_stall_off", 32'(cpu_stall_req_o), 32'd0);
    check_output("c_mem_idle", 32'(mem_req_o), 32'd0);

    // Starvation: limit 2 -> CPU, CPU, DBG, CPU
    dbg_req_i = 1'b1; dbg_we_i = 1'b0; dbg_addr_i = 32'h500;
    cpu_load_i = 1'b1; cpu_addr_i = 32'h10; cpu_sel_i = 4'hF;
    tick();
    cpu_load_i = 1'b0;
    check_output("d_grant1", mem_addr_o, 32'h10);
    cpu_load_i = 1'b1; cpu_addr_i = 32'h20; mem_ack_i = 1'b1; mem_data_i = 32'h1;
    tick();
    check_output("d_grant2", mem_addr_o, 32'h20);
    check_output("d_done1", 32'(cpu_load_done_o), 32'd1);
    cpu_addr_i = 32'h30; mem_data_i = 32'h2;
    tick();
    cpu_load_i = 1'b0;
    check_output("d_grant3_dbg", mem_addr_o, 32'h500);
    check_output("d_pend_stall", 32'(cpu_stall_req_o), 32'd1);
    mem_data_i = 32'h77;
    tick();
    check_output("d_grant4", mem_addr_o, 32'h30);
    check_output("d_dbg_ack", 32'(dbg_ack_o), 32'd1);
    check_output("d_dbg_data", dbg_data_o, 32'h77);
    dbg_req_i = 1'b0; mem_data_i = 32'h88;
    tick();
    mem_ack_i = 1'b0;
    check_output("d_done4", 32'(cpu_load_done_o), 32'd1);
    check_output("d_cpu_data", cpu_data_o, 32'h88);
    check_output("d_mem_idle", 32'(mem_req_o), 32'd0);

    // Zero-wait memory, alternating CPU and debug
    mem_ack_i = 1'b1; mem_data_i = 32'h11;
    cpu_load_i = 1'b1; cpu_addr_i = 32'h40;
    tick();
    cpu_load_i = 1'b0;
    check_output("e_cpu1", mem_addr_o, 32'h40);
    dbg_req_i = 1'b1; dbg_addr_i = 32'h600; dbg_we_i = 1'b0; mem_data_i = 32'h22;
    tick();
    check_output("e_done1", 32'(cpu_load_done_o), 32'd1);
    check_output("e_cpu_data1", cpu_data_o, 32'h22);
    check_output("e_dbg", mem_addr_o, 32'h600);
    cpu_load_i = 1'b1; cpu_addr_i = 32'h50; mem_data_i = 32'h33;
    tick();
    cpu_load_i = 1'b0;
    check_output("e_dbg_ack", 32'(dbg_ack_o), 32'd1);
    check_output("e_dbg_data", dbg_data_o, 32'h33);
    check_output("e_cpu2", mem_addr_o, 32'h50);
    check_output("e_cpu2_req", 32'(mem_req_o), 32'd1);
    mem_data_i = 32'h44;
    tick();
    check_output("e_no_dup_dbg", 32'(mem_req_o), 32'd0);
    check_output("e_done2", 32'(cpu_load_done_o), 32'd1);
    check_output("e_cpu_data2", cpu_data_o, 32'h44);
    check_output("e_ack_pulse", 32'(dbg_ack_o), 32'd0);
    dbg_req_i = 1'b0; mem_ack_i = 1'b0;
    tick();

    // Reset in the middle of a CPU access with a pending request
    cpu_load_i = 1'b1; cpu_addr_i = 32'h70;
    tick();
    cpu_load_i = 1'b0;
    cpu_store_i = 1'b1; cpu_addr_i = 32'h80;
    tick();
    cpu_store_i = 1'b0;
    check_output("f_stall", 32'(cpu_stall_req_o), 32'd1);
    check_output("f_addr", mem_addr_o, 32'h70);
    rst_i = 1'b1;
    #1;
    check_output("f_rst_req", 32'(mem_req_o), 32'd0);
    check_output("f_rst_stall", 32'(cpu_stall_req_o), 32'd0);
    check_output("f_rst_addr", mem_addr_o, 32'd0);
    tick(); tick();
    rst_i = 1'b0; mem_ack_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_output("f_post_done", 32'(cpu_load_done_o), 32'd0);
      check_output("f_post_ack", 32'(dbg_ack_o), 32'd0);
      check_output("f_post_req", 32'(mem_req_o), 32'd0);
      check_output("f_post_stall", 32'(cpu_stall_req_o), 32'd0);
    end
    mem_ack_i = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
